// File: rtl/data_mem_responder.sv
// Data-memory bus responder: word-organised RAM with byte-lane writes,
// fixed-latency pipelined reads and a sticky out-of-window error flag.
module data_mem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_rd_i,
    input  logic [3:0]  d_we_i,
    output logic [31:0] d_data_o,
    output logic        d_valid_o,
    output logic        err_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LAT = READ_LATENCY;

    logic [29:0]   word_off_c;
    logic          in_range_c;
    logic [AW-1:0] index_c;
    logic          rd_req_c;
    logic          wr_req_c;
    logic [31:0]   lane_mask_c;
    logic [31:0]   rd_word_c;
    logic          addr_unused;

    logic [31:0] mem [DEPTH];

    logic        pipe_valid [LAT];
    logic [31:0] pipe_data  [LAT];

    // Address decode: offset from the window base wraps in 30 bits.
    assign word_off_c  = d_addr_i[31:2] - BASE_ADDR[31:2];
    assign in_range_c  = word_off_c < 30'(DEPTH);
    assign index_c     = word_off_c[AW-1:0];
    assign rd_req_c    = |d_rd_i;
    assign wr_req_c    = |d_we_i;
    assign lane_mask_c = {{8{d_rd_i[3]}}, {8{d_rd_i[2]}}, {8{d_rd_i[1]}}, {8{d_rd_i[0]}}};
    assign addr_unused = ^{d_addr_i[1:0], word_off_c[29:AW]};

    // Read word as seen before this edge's write (read-before-write).
    assign rd_word_c = in_range_c ? (mem[index_c] & lane_mask_c) : 32'h0;

    // RAM write port with per-byte lane enables; out-of-window writes dropped.
    always_ff @(posedge clk_i) begin
        if (wr_req_c && in_range_c) begin
            for (int n = 0; n < 4; n++) begin
                if (d_we_i[n]) begin
                    mem[index_c][8*n +: 8] <= d_data_i[8*n +: 8];
                end
            end
        end
    end

    // First read stage and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_valid[0] <= 1'b0;
            pipe_data[0]  <= 32'h0;
            err_o         <= 1'b0;
        end else begin
            pipe_valid[0] <= rd_req_c;
            if (rd_req_c) begin
                pipe_data[0] <= rd_word_c;
            end
            if ((rd_req_c || wr_req_c) && !in_range_c) begin
                err_o <= 1'b1;
            end
        end
    end

    // Remaining read stages; data only advances with a valid so the last
    // stage holds the most recently returned value.
    for (genvar g = 1; g < LAT; g++) begin : g_stage
        // Stage g of the read pipeline.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                pipe_valid[g] <= 1'b0;
                pipe_data[g]  <= 32'h0;
            end else begin
                pipe_valid[g] <= pipe_valid[g-1];
                if (pipe_valid[g-1]) begin
                    pipe_data[g] <= pipe_data[g-1];
                end
            end
        end
    end

    assign d_valid_o = pipe_valid[LAT-1];
    assign d_data_o  = pipe_data[LAT-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder against a
// behavioural byte-array model with a latency delay line.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned LAT   = 3;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [3:0]  d_rd_i;
    logic [3:0]  d_we_i;
    logic [31:0] d_data_o;
    logic        d_valid_o;
    logic        err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mdl_mem [DEPTH];
    bit          hist_v [$];
    logic [31:0] hist_d [$];
    logic [31:0] last_data;
    bit          exp_valid;
    bit          mdl_err;

    data_mem_responder #(
        .DEPTH        (DEPTH),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .d_addr_i  (d_addr_i),
        .d_data_i  (d_data_i),
        .d_rd_i    (d_rd_i),
        .d_we_i    (d_we_i),
        .d_data_o  (d_data_o),
        .d_valid_o (d_valid_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist_v.delete();
        hist_d.delete();
        last_data = 32'h0;
        exp_valid = 1'b0;
        mdl_err   = 1'b0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] off;
        logic [31:0] rdv;
        bit          inw;
        int unsigned idx;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        off = (d_addr_i & 32'hFFFF_FFFC) - BASE;
        inw = off < DEPTH * 4;
        idx = inw ? int'(off / 4) : 0;
        rdv = 32'h0;
        if (d_rd_i != 4'h0 && inw) begin
            for (int n = 0; n < 4; n++) begin
                if (d_rd_i[n]) rdv[8*n +: 8] = mdl_mem[idx][8*n +: 8];
            end
        end
        if (d_we_i != 4'h0 && inw) begin
            for (int n = 0; n < 4; n++) begin
                if (d_we_i[n]) mdl_mem[idx][8*n +: 8] = d_data_i[8*n +: 8];
            end
        end
        if ((d_rd_i != 4'h0 || d_we_i != 4'h0) && !inw) mdl_err = 1'b1;
        hist_v.push_back(d_rd_i != 4'h0);
        hist_d.push_back(rdv);
        while (hist_v.size() > LAT) begin
            void'(hist_v.pop_front());
            void'(hist_d.pop_front());
        end
        exp_valid = (hist_v.size() == LAT) && hist_v[0];
        if (exp_valid) last_data = hist_d[0];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(d_valid_o), 32'(exp_valid));
        check({tag, ".data"},  d_data_o, last_data);
        check({tag, ".err"},   32'(err_o), 32'(mdl_err));
    endtask

    task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] rd, input logic [3:0] we);
        d_addr_i = addr;
        d_data_i = data;
        d_rd_i   = rd;
        d_we_i   = we;
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic flush();
        repeat (LAT) step("flush", 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    initial begin
        rst_n_i  = 1'b0;
        d_addr_i = 32'h0;
        d_data_i = 32'h0;
        d_rd_i   = 4'h0;
        d_we_i   = 4'h0;
        model_reset();
        repeat (2) step("reset", 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Fill the whole RAM so every later read has a known answer.
        for (int i = 0; i < DEPTH; i++) step("fill", BASE + 32'(4 * i), $urandom, 4'h0, 4'hF);

        // Full-word write then read back.
        step("t1_wr", 32'h1000, 32'hDEAD_BEEF, 4'h0, 4'hF);
        step("t1_rd", 32'h1000, 32'h0, 4'hF, 4'h0);
        flush();
        check("t1_data", d_data_o, 32'hDEAD_BEEF);

        // Single-lane write and lane-masked reads.
        step("t2_wr",  32'h1000, 32'h0000_00AA, 4'h0, 4'b0010);
        step("t2_rdf", 32'h1000, 32'h0, 4'hF, 4'h0);
        step("t2_rd0", 32'h1000, 32'h0, 4'b0001, 4'h0);
        flush();
        check("t2_data", d_data_o, 32'h0000_00EF);

        // Same-cycle read and write returns old contents; next read sees new.
        step("t3_pre", 32'h1004, 32'h2222_2222, 4'h0, 4'hF);
        step("t3_rw",  32'h1004, 32'h1111_1111, 4'hF, 4'hF);
        check("t3_rw_none", 32'(d_valid_o), 32'h0);
        step("t3_rd",  32'h1004, 32'h0, 4'hF, 4'h0);
        step("t3_w1",  32'h0, 32'h0, 4'h0, 4'h0);
        check("t3_old", d_data_o, 32'h2222_2222);
        step("t3_w2",  32'h0, 32'h0, 4'h0, 4'h0);
        check("t3_new", d_data_o, 32'h1111_1111);

        // Back-to-back reads come out as consecutive pulses in order.
        step("t4_a", 32'h1000, 32'h0, 4'hF, 4'h0);
        step("t4_b", 32'h1004, 32'h0, 4'hF, 4'h0);
        step("t4_c", 32'h1008, 32'h0, 4'hF, 4'h0);
        flush();

        // Random in-window traffic.
        for (int i = 0; i < 400; i++) begin
            step("rnd_in", BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3)),
                 $urandom, ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
        end
        flush();
        check("pre_err", 32'(err_o), 32'h0);

        // Out-of-window write is dropped, read returns zero, error sticks.
        step("t5_wr", 32'h0FFC, 32'hCAFE_F00D, 4'h0, 4'hF);
        check("t5_err_set", 32'(err_o), 32'h1);
        step("t5_rd", BASE + DEPTH * 4, 32'h0, 4'hF, 4'h0);
        flush();
        check("t5_rd_zero", d_data_o, 32'h0);
        step("t5_w63", BASE + 4 * (DEPTH - 1), 32'h0, 4'hF, 4'h0);
        step("t5_w0",  BASE, 32'h0, 4'hF, 4'h0);
        flush();
        check("t5_err_hold", 32'(err_o), 32'h1);

        // Reset while a read is in flight discards it.
        step("t6_rd", 32'h1000, 32'h0, 4'hF, 4'h0);
        #1;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check("t6_valid", 32'(d_valid_o), 32'h0);
        check("t6_data",  d_data_o, 32'h0);
        check("t6_err",   32'(err_o), 32'h0);
        repeat (LAT + 1) step("t6_inrst", 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step("t6_first", 32'h1000, 32'h0, 4'hF, 4'h0);
        step("t6_second", 32'h1004, 32'h0, 4'hF, 4'h0);
        flush();

        // Random traffic including out-of-window addresses.
        for (int i = 0; i < 300; i++) begin
            step("rnd_mix", 32'h0F00 + 32'($urandom_range(0, 32'h300)), $urandom,
                 ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
